// File: rtl/read_74hc165d.sv
// Frame reader for a 74HC165 parallel-in/serial-out shift register.
// Loads the register, clocks out WIDTH bits MSB-first and presents them as a word.
module read_74hc165d #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic             s_clk,
  input  logic             s_reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             data_in,
  output logic             load_n,
  output logic             clk_inh,
  output logic             data_clock,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic [BW-1:0]    bits, bits_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             phase_end;

  assign phase_end = (phase == PW'(CLK_DIV - 1));

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + PW'(1);
    bits_nxt  = bits;
    shreg_nxt = shreg;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        bits_nxt  = '0;
        if (start || continuous) state_nxt = LOAD;
      end
      LOAD: begin
        if (phase_end) begin
          phase_nxt = '0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        // Sample at the end of the low phase so Q7 has settled after the last shift.
        if (phase_end) begin
          phase_nxt = '0;
          shreg_nxt = {shreg[WIDTH-2:0], data_in};
          bits_nxt  = bits + BW'(1);
          state_nxt = (bits_nxt == BW'(WIDTH)) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          phase_nxt = '0;
          state_nxt = LOW;
        end
      end
      DONE: begin
        phase_nxt = '0;
        bits_nxt  = '0;
        state_nxt = continuous ? LOAD : IDLE;
      end
      default: begin
        phase_nxt = '0;
        bits_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state itself.
  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      state      <= IDLE;
      phase      <= '0;
      bits       <= '0;
      shreg      <= '0;
      load_n     <= 1'b1;
      clk_inh    <= 1'b1;
      data_clock <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bits       <= bits_nxt;
      shreg      <= shreg_nxt;
      load_n     <= (state_nxt != LOAD);
      clk_inh    <= (state_nxt == IDLE) || ((state_nxt == DONE) && !continuous);
      data_clock <= (state_nxt == HIGH);
      data_valid <= (state_nxt == DONE);
      busy       <= (state_nxt == LOAD) || (state_nxt == LOW) || (state_nxt == HIGH);
      if (state_nxt == DONE) data_out <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_read_74hc165d.sv
// Bench for read_74hc165d: two instances (16-bit/div 2 and 8-bit/div 1) driving
// behavioural 74HC165 models, checked against frame value, latency and edge counts.
module tb_read_74hc165d;

  logic s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  logic        s_reset_n;
  logic        start_a, start_b, cont_a, cont_b;
  logic        din_a, din_b;
  logic        load_n_a, inh_a, dc_a, dv_a, busy_a;
  logic        load_n_b, inh_b, dc_b, dv_b, busy_b;
  logic [15:0] dout_a;
  logic [7:0]  dout_b;

  read_74hc165d dut_a (
    .s_clk(s_clk), .s_reset_n(s_reset_n), .start(start_a), .continuous(cont_a),
    .data_in(din_a), .load_n(load_n_a), .clk_inh(inh_a), .data_clock(dc_a),
    .data_out(dout_a), .data_valid(dv_a), .busy(busy_a)
  );

  read_74hc165d #(.WIDTH(8), .CLK_DIV(1)) dut_b (
    .s_clk(s_clk), .s_reset_n(s_reset_n), .start(start_b), .continuous(cont_b),
    .data_in(din_b), .load_n(load_n_b), .clk_inh(inh_b), .data_clock(dc_b),
    .data_out(dout_b), .data_valid(dv_b), .busy(busy_b)
  );

  // 74HC165 models: parallel load on SH/LD low, shift toward Q7 on CLK rise when not inhibited.
  logic [15:0] par_a = 16'h0, sh_a = 16'h0;
  logic [7:0]  par_b = 8'h0,  sh_b = 8'h0;
  always @(negedge load_n_a or posedge dc_a)
    if (!load_n_a) sh_a <= par_a;
    else if (!inh_a) sh_a <= {sh_a[14:0], 1'b0};
  always @(negedge load_n_b or posedge dc_b)
    if (!load_n_b) sh_b <= par_b;
    else if (!inh_b) sh_b <= {sh_b[6:0], 1'b0};
  assign din_a = sh_a[15];
  assign din_b = sh_b[7];

  logic        sel = 1'b0;
  logic        m_valid, m_busy, m_load_n, m_inh, m_dc;
  logic [31:0] m_dout;
  assign m_valid  = sel ? dv_b     : dv_a;
  assign m_busy   = sel ? busy_b   : busy_a;
  assign m_load_n = sel ? load_n_b : load_n_a;
  assign m_inh    = sel ? inh_b    : inh_a;
  assign m_dc     = sel ? dc_b     : dc_a;
  assign m_dout   = sel ? {24'h0, dout_b} : {16'h0, dout_a};

  int   edges = 0, loads = 0, valids = 0;
  logic dc_prev = 1'b0;
  always @(negedge s_clk) begin
    if (m_dc && !dc_prev) edges <= edges + 1;
    dc_prev <= m_dc;
    if (!m_load_n) loads <= loads + 1;
    if (m_valid) valids <= valids + 1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_par(input logic [31:0] val);
    if (sel) par_b = val[7:0];
    else par_a = val[15:0];
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  // Ends half a cycle after the accepting edge.
  task automatic pulse_start();
    @(negedge s_clk);
    set_start(1'b1);
    @(negedge s_clk);
    set_start(1'b0);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!m_valid && cyc < 300) begin
      @(negedge s_clk);
      cyc++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".load_n"}, {31'h0, m_load_n}, 32'd1);
    check({tag, ".clk_inh"}, {31'h0, m_inh}, 32'd1);
    check({tag, ".data_clock"}, {31'h0, m_dc}, 32'd0);
    check({tag, ".data_valid"}, {31'h0, m_valid}, 32'd0);
    check({tag, ".busy"}, {31'h0, m_busy}, 32'd0);
    check({tag, ".data_out"}, m_dout, 32'd0);
  endtask

  task automatic read_frame(input string tag, input logic [31:0] val, input int w, input int cd);
    int cyc, l0, e0, v0;
    set_par(val);
    @(negedge s_clk);
    #1;
    l0 = loads; e0 = edges; v0 = valids;
    pulse_start();
    check({tag, ".busy_on_accept"}, {31'h0, m_busy}, 32'd1);
    check({tag, ".load_n_on_accept"}, {31'h0, m_load_n}, 32'd0);
    wait_valid(cyc);
    check({tag, ".latency"}, cyc, 2 * w * cd);
    check({tag, ".data_out"}, m_dout, val);
    check({tag, ".busy_at_valid"}, {31'h0, m_busy}, 32'd0);
    @(negedge s_clk);
    #1;
    check({tag, ".load_cycles"}, loads - l0, cd);
    check({tag, ".clock_edges"}, edges - e0, w - 1);
    check({tag, ".valid_pulses"}, valids - v0, 32'd1);
    check({tag, ".busy_after"}, {31'h0, m_busy}, 32'd0);
    check({tag, ".clk_inh_after"}, {31'h0, m_inh}, 32'd1);
    check({tag, ".data_out_hold"}, m_dout, val);
  endtask

  initial begin
    int cyc, t, v0, e0, k;
    logic [31:0] rv;
    s_reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; cont_a = 1'b0; cont_b = 1'b0;
    repeat (3) @(negedge s_clk);
    check_reset_values("reset");
    s_reset_n = 1'b1;
    repeat (2) @(negedge s_clk);

    read_frame("single", 32'hA5C3, 16, 2);

    // start re-pulsed mid-frame is neither honoured nor queued
    par_a = 16'hA5C3;
    @(negedge s_clk);
    #1;
    v0 = valids;
    pulse_start();
    repeat (9) @(negedge s_clk);
    start_a = 1'b1;
    @(negedge s_clk);
    start_a = 1'b0;
    wait_valid(cyc);
    t = 10 + cyc;
    check("restart.latency", t, 64);
    check("restart.data_out", m_dout, 32'hA5C3);
    repeat (150) @(negedge s_clk);
    #1;
    check("restart.valid_pulses", valids - v0, 1);
    check("restart.busy", {31'h0, m_busy}, 32'd0);

    // continuous: two back-to-back frames, mode dropped during the second
    par_a = 16'h1234;
    @(negedge s_clk);
    #1;
    v0 = valids;
    cont_a = 1'b1;
    @(negedge s_clk);
    wait_valid(cyc);
    check("cont.latency1", cyc, 64);
    check("cont.data1", m_dout, 32'h1234);
    par_a = 16'hFFFF;
    cyc = 0;
    do begin
      @(negedge s_clk);
      cyc++;
      if (cyc == 20) cont_a = 1'b0;
    end while (!m_valid && cyc < 300);
    check("cont.spacing", cyc, 65);
    check("cont.data2", m_dout, 32'hFFFF);
    check("cont.clk_inh_done", {31'h0, m_inh}, 32'd1);
    repeat (150) @(negedge s_clk);
    #1;
    check("cont.valid_pulses", valids - v0, 2);
    check("cont.idle_busy", {31'h0, m_busy}, 32'd0);
    check("cont.idle_load_n", {31'h0, m_load_n}, 32'd1);

    // reset mid-frame aborts without a valid pulse
    rv = {16'h0, 16'($urandom)};
    par_a = rv[15:0];
    @(negedge s_clk);
    #1;
    v0 = valids; e0 = edges;
    pulse_start();
    k = 0;
    while (edges - e0 < 8 && k < 300) begin
      @(negedge s_clk);
      k++;
    end
    check("abort.reached_edge8", {31'h0, (k < 300)}, 32'd1);
    s_reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge s_clk);
    s_reset_n = 1'b1;
    repeat (150) @(negedge s_clk);
    #1;
    check("abort.valid_pulses", valids - v0, 0);
    check("abort.idle_busy", {31'h0, m_busy}, 32'd0);
    read_frame("after_abort", rv, 16, 2);

    for (int i = 0; i < 3; i++) begin
      rv = {16'h0, 16'($urandom)};
      read_frame("rand16", rv, 16, 2);
    end

    sel = 1'b1;
    repeat (2) @(negedge s_clk);
    read_frame("w8", 32'h81, 8, 1);
    for (int i = 0; i < 4; i++) begin
      rv = {24'h0, 8'($urandom_range(0, 255))};
      read_frame("rand8", rv, 8, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
